// File: rtl/endec_job_arbiter_pkg.sv
// ============================================================================
// endec_job_arbiter_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared widths, the job configuration layout and the FSM state type
//           for the endec job arbiter and its round-robin grant helper.
// Contents: width localparams for the endec job and result fields
//           endec_cfg_t  packed layout of one job configuration word
//           arb_state_t  2-bit FSM state encoding (IDLE/LOAD/RUN/RESP)
// ============================================================================
package endec_job_arbiter_pkg;

    // Generator polynomial storage is constraint length times code rate.
    localparam int MAX_CONSTRAINT_LENGTH = 9;
    localparam int MAX_CODE_RATE         = 3;
    localparam int MAX_STATE_REG_NUM     = 8;

    localparam int GEN_POLY_W  = MAX_CONSTRAINT_LENGTH * MAX_CODE_RATE;
    // prv_state + code_rate bit + gen_poly = 8 + 1 + 27 = 36
    localparam int ENDEC_CFG_W = MAX_STATE_REG_NUM + 1 + GEN_POLY_W;

    localparam int ENC_FRAME_W = 128;   // encoder input frame
    localparam int DEC_FRAME_W = 384;   // decoder input frame
    localparam int ENC_DATA_W  = 384;   // encoder result
    localparam int DEC_DATA_W  = 128;   // decoder result

    localparam int WDT_CNT_W   = 16;    // watchdog cycle counter width

    typedef struct packed {
        logic [MAX_STATE_REG_NUM-1:0] prv_state;
        logic                         code_rate;
        logic [GEN_POLY_W-1:0]        gen_poly;
    } endec_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/endec_rr_arbiter.sv
// ============================================================================
// endec_rr_arbiter
// ----------------------------------------------------------------------------
// Purpose : Combinational round-robin pick. Starting at rr_ptr and wrapping
//           from NUM_REQ-1 back to 0, the first asserted request wins.
// Ports   : req_valid     in  NUM_REQ  per-requester request
//           rr_ptr        in  ID_W     index with the highest priority
//           grant_onehot  out NUM_REQ  one-hot winner (0 if no request)
//           grant_idx     out ID_W     binary winner index (0 if no request)
//           any_valid     out 1        at least one request asserted
// ============================================================================
module endec_rr_arbiter
    import endec_job_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_valid
);

    int               cand;
    logic [ID_W-1:0]  cand_idx;

    // Walk the requesters in priority order; the first hit locks the grant.
    // NUM_REQ need not be a power of two, so the wrap is an explicit subtract.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any_valid    = 1'b0;
        cand         = 0;
        cand_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!any_valid && req_valid[cand_idx]) begin
                any_valid              = 1'b1;
                grant_idx              = cand_idx;
                grant_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/endec_job_arbiter.sv
// ============================================================================
// endec_job_arbiter
// ----------------------------------------------------------------------------
// Purpose : Shares one endec core among NUM_REQ requesters. Picks a job
//           round-robin, latches it, flushes the core (LOAD), runs it (RUN),
//           waits for both encoder and decoder done, then presents the result
//           tagged with the owning requester until the consumer accepts it.
//           This is the only block that drives the core rst/en pins.
//
// Optional: `define ENDEC_ARB_WDT_EN adds a RUN-state watchdog. After
//           TIMEOUT_CYCLES cycles in RUN without both dones the job is
//           returned with rsp_err=1 and zero data. Without the macro RUN
//           waits indefinitely and rsp_err is always 0.
//
// Ports   : sys_clk        in   1            clock, posedge
//           rst_n          in   1            async active-low reset
//           req_valid      in   NUM_REQ      per-requester job valid
//           req_ready      out  NUM_REQ      one-hot accept, IDLE only
//           req_cfg        in   NUM_REQ*36   per-requester job config
//           req_enc_frame  in   NUM_REQ*128  encoder input frames
//           req_dec_frame  in   NUM_REQ*384  decoder input frames
//           rsp_valid      out  1            result valid, held until ready
//           rsp_ready      in   1            result consumer ready
//           rsp_id         out  ID_W         owner of the result
//           rsp_enc_data   out  384          encoder result snapshot
//           rsp_dec_data   out  128          decoder result snapshot
//           rsp_err        out  1            watchdog abort, data zero
//           busy           out  1            not IDLE
//           core_rst       out  1            core reset (0 = held in reset)
//           core_en        out  1            core enable
//           core_cfg/enc/dec out 36/128/384  latched job to the core
//           core_enc_done, core_dec_done in 1  core done flags
//           core_enc_data, core_dec_data in 384/128  core results
// ============================================================================
module endec_job_arbiter
    import endec_job_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,

    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ENDEC_CFG_W-1:0] req_cfg,
    input  logic [NUM_REQ*ENC_FRAME_W-1:0] req_enc_frame,
    input  logic [NUM_REQ*DEC_FRAME_W-1:0] req_dec_frame,

    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [ENC_DATA_W-1:0]          rsp_enc_data,
    output logic [DEC_DATA_W-1:0]          rsp_dec_data,
    output logic                           rsp_err,
    output logic                           busy,

    output logic                           core_rst,
    output logic                           core_en,
    output logic [ENDEC_CFG_W-1:0]         core_cfg,
    output logic [ENC_FRAME_W-1:0]         core_enc,
    output logic [DEC_FRAME_W-1:0]         core_dec,
    input  logic                           core_enc_done,
    input  logic                           core_dec_done,
    input  logic [ENC_DATA_W-1:0]          core_enc_data,
    input  logic [DEC_DATA_W-1:0]          core_dec_data
);

    arb_state_t          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]     grant_idx;
    logic                any_valid;
    logic                enc_seen;
    logic                dec_seen;
    logic                both_done;
    logic                wdt_expired;
    endec_cfg_t          sel_cfg;

    endec_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_valid    (req_valid),
        .rr_ptr       (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any_valid    (any_valid)
    );

    // Accept is offered only while idle; a response being drained in RESP
    // never overlaps with a new grant.
    assign req_ready = (state == ST_IDLE && any_valid) ? grant_onehot : '0;
    assign busy      = (state != ST_IDLE);

    // A done seen in an earlier RUN cycle counts the same as a live one,
    // so simultaneous and skewed completions take the same path.
    assign both_done = (enc_seen | core_enc_done) & (dec_seen | core_dec_done);

    assign sel_cfg = endec_cfg_t'(req_cfg[int'(grant_idx)*ENDEC_CFG_W +: ENDEC_CFG_W]);

`ifdef ENDEC_ARB_WDT_EN
    localparam logic [WDT_CNT_W-1:0] WDT_LIMIT = WDT_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [WDT_CNT_W-1:0] wdt_cnt;

    // Counter is zero on the first RUN cycle and equals the number of RUN
    // cycles already spent, so the limit fires on RUN cycle TIMEOUT_CYCLES-1.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
        end else if (state == ST_LOAD) begin
            wdt_cnt <= '0;
        end else if (state == ST_RUN) begin
            wdt_cnt <= wdt_cnt + WDT_CNT_W'(1);
        end
    end

    assign wdt_expired = (wdt_cnt == WDT_LIMIT);
`else
    assign wdt_expired = 1'b0;
`endif

    // Job FSM plus job/result registers. LOAD holds the core in reset for one
    // cycle with the new job already on core_cfg/enc/dec, so the core starts
    // from a clean state. RESP keeps core_rst high and core_en low so the core
    // outputs freeze while the consumer stalls.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            enc_seen     <= 1'b0;
            dec_seen     <= 1'b0;
            core_rst     <= 1'b0;
            core_en      <= 1'b0;
            core_cfg     <= '0;
            core_enc     <= '0;
            core_dec     <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_enc_data <= '0;
            rsp_dec_data <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        core_cfg <= sel_cfg;
                        core_enc <= req_enc_frame[int'(grant_idx)*ENC_FRAME_W +: ENC_FRAME_W];
                        core_dec <= req_dec_frame[int'(grant_idx)*DEC_FRAME_W +: DEC_FRAME_W];
                        rsp_id   <= grant_idx;
                        rr_ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                      : grant_idx + ID_W'(1);
                        enc_seen <= 1'b0;
                        dec_seen <= 1'b0;
                        core_rst <= 1'b0;
                        core_en  <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    core_rst <= 1'b1;
                    core_en  <= 1'b1;
                    state    <= ST_RUN;
                end

                ST_RUN: begin
                    enc_seen <= enc_seen | core_enc_done;
                    dec_seen <= dec_seen | core_dec_done;
                    if (both_done) begin
                        rsp_enc_data <= core_enc_data;
                        rsp_dec_data <= core_dec_data;
                        rsp_err      <= 1'b0;
                        rsp_valid    <= 1'b1;
                        core_en      <= 1'b0;
                        state        <= ST_RESP;
                    end else if (wdt_expired) begin
                        rsp_enc_data <= '0;
                        rsp_dec_data <= '0;
                        rsp_err      <= 1'b1;
                        rsp_valid    <= 1'b1;
                        core_en      <= 1'b0;
                        state        <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        core_rst  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
